// File: rtl/spike_rate_decoder.sv
// Spike-to-rate decoder: counts spikes per channel over a programmable window,
// latches one rate frame per window and keeps a registered winner-take-all index.
// Optional build macro SPIKE_DEC_EMA_EN: latched rates become a running average (old+new)/2.
module spike_rate_decoder #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_CH-1:0]          spike_in,
  input  logic [WIN_W-1:0]         win_len,
  input  logic [$clog2(N_CH)-1:0]  rate_sel,
  output logic [CNT_W-1:0]         rate_out,
  output logic                     frame_valid,
  output logic [$clog2(N_CH)-1:0]  winner,
  output logic                     winner_valid,
  output logic                     overflow
);

  localparam int SEL_W = $clog2(N_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state, state_next;
  logic [WIN_W:0]   win_cnt, win_cnt_next, remaining;
  logic [CNT_W-1:0] ch_cnt   [N_CH];
  logic [CNT_W-1:0] latched  [N_CH];
  logic [CNT_W-1:0] new_cnt  [N_CH];
  logic [CNT_W-1:0] lat_next [N_CH];
  logic [N_CH-1:0]  sat_hit;
  logic             sat_acc;
  logic             last;
  logic [SEL_W-1:0] best_idx;
  logic [CNT_W-1:0] best_val;
`ifdef SPIKE_DEC_EMA_EN
  logic [CNT_W:0]   ema_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // In IDLE the window length is taken straight from win_len so the first
  // enabled cycle both starts the window and is counted (no gap between windows).
  always_comb begin
    state_next   = state;
    win_cnt_next = win_cnt;
    last         = 1'b0;
    if (state == IDLE)
      remaining = (win_len == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, win_len};
    else
      remaining = win_cnt;
    if (en) begin
      if (remaining == (WIN_W+1)'(1)) begin
        last       = 1'b1;
        state_next = IDLE;
      end else begin
        state_next   = COUNT;
        win_cnt_next = remaining - (WIN_W+1)'(1);
      end
    end
  end

  always_comb begin
`ifdef SPIKE_DEC_EMA_EN
    ema_sum = '0;
`endif
    for (int unsigned i = 0; i < N_CH; i++) begin
      sat_hit[i] = spike_in[i] && (ch_cnt[i] == CNT_MAX);
      new_cnt[i] = sat_hit[i] ? CNT_MAX : ch_cnt[i] + CNT_W'(spike_in[i]);
`ifdef SPIKE_DEC_EMA_EN
      ema_sum     = {1'b0, latched[i]} + {1'b0, new_cnt[i]};
      lat_next[i] = ema_sum[CNT_W:1];
`else
      lat_next[i] = new_cnt[i];
`endif
    end
  end

  // Winner is computed from the values about to be latched so it lands with frame_valid.
  always_comb begin
    best_idx = '0;
    best_val = lat_next[0];
    for (int unsigned i = 1; i < N_CH; i++) begin
      if (lat_next[i] > best_val) begin
        best_val = lat_next[i];
        best_idx = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt      <= '0;
      sat_acc      <= 1'b0;
      frame_valid  <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
      overflow     <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        ch_cnt[i]  <= '0;
        latched[i] <= '0;
      end
    end else begin
      frame_valid <= last;
      if (en) begin
        win_cnt <= win_cnt_next;
        if (last) begin
          sat_acc      <= 1'b0;
          overflow     <= sat_acc | (|sat_hit);
          winner       <= best_idx;
          winner_valid <= (best_val != '0);
          for (int unsigned i = 0; i < N_CH; i++) begin
            ch_cnt[i]  <= '0;
            latched[i] <= lat_next[i];
          end
        end else begin
          sat_acc <= sat_acc | (|sat_hit);
          for (int unsigned i = 0; i < N_CH; i++)
            ch_cnt[i] <= new_cnt[i];
        end
      end
    end
  end

  assign rate_out = latched[rate_sel];

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed table, corner sequences,
// and randomized traffic against a count-per-window reference model.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [7:0] spike_in, win_len, rate_out;
  logic [2:0] rate_sel, winner;
  logic       frame_valid, winner_valid, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: unbounded per-window counts, saturation applied at frame time.
  int m_cnt [8];
  int m_lat [8];
  int m_rem;
  bit m_act, m_fv, m_wv, m_ov;
  int m_win;

  spike_rate_decoder #(.N_CH(8), .CNT_W(8), .WIN_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .win_len(win_len),
    .rate_sel(rate_sel), .rate_out(rate_out), .frame_valid(frame_valid),
    .winner(winner), .winner_valid(winner_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input logic [7:0] sp, input logic [7:0] wl);
    int sat;
    if (r) begin
      for (int i = 0; i < 8; i++) begin m_cnt[i] = 0; m_lat[i] = 0; end
      m_act = 0; m_rem = 0; m_fv = 0; m_wv = 0; m_ov = 0; m_win = 0;
    end else begin
      m_fv = 0;
      if (e) begin
        if (!m_act) begin
          m_rem = (wl == 0) ? 256 : int'(wl);
          m_act = 1;
        end
        for (int i = 0; i < 8; i++) m_cnt[i] += int'(sp[i]);
        m_rem--;
        if (m_rem == 0) begin
          m_ov = 0;
          for (int i = 0; i < 8; i++) begin
            sat = (m_cnt[i] > 255) ? 255 : m_cnt[i];
            if (m_cnt[i] > 255) m_ov = 1;
`ifdef SPIKE_DEC_EMA_EN
            m_lat[i] = (m_lat[i] + sat) / 2;
`else
            m_lat[i] = sat;
`endif
            m_cnt[i] = 0;
          end
          m_win = 0;
          for (int i = 1; i < 8; i++)
            if (m_lat[i] > m_lat[m_win]) m_win = i;
          m_wv  = (m_lat[m_win] != 0);
          m_act = 0;
          m_fv  = 1;
        end
      end
    end
  endtask

  task automatic tick(input bit r, input bit e, input logic [7:0] sp, input logic [7:0] wl,
                      input logic [2:0] sel);
    rst = r; en = e; spike_in = sp; win_len = wl; rate_sel = sel;
    @(posedge clk);
    model_step(r, e, sp, wl);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_fv"},   32'(frame_valid),  32'(m_fv));
    chk({tag, "_win"},  32'(winner),       32'(m_win));
    chk({tag, "_wv"},   32'(winner_valid), 32'(m_wv));
    chk({tag, "_ov"},   32'(overflow),     32'(m_ov));
    chk({tag, "_rate"}, 32'(rate_out),     32'(m_lat[rate_sel]));
  endtask

  typedef struct {
    logic [7:0] wl;
    logic [7:0] sp_even;   // spikes on even-numbered enabled cycles
    logic [7:0] sp_odd;    // spikes on odd-numbered enabled cycles
    bit         toggle;    // en alternates 1/0, disabled cycles carry 0xFF spikes
    int         cyc;       // edges until the frame appears
    logic [2:0] ch;
    logic [7:0] rate;
    logic [2:0] win;
    bit         wv;
    bit         ov;
  } vec_t;

  initial begin
    vec_t tv [8];
    int   k;
    bit   e, early;
    logic [7:0] sp;

    tv[0] = '{8'd10,  8'h00, 8'h08, 1'b0, 10,  3'd3, 8'd5,   3'd3, 1'b1, 1'b0};
    tv[1] = '{8'd4,   8'h24, 8'h24, 1'b0, 4,   3'd5, 8'd4,   3'd2, 1'b1, 1'b0};
    tv[2] = '{8'd0,   8'h01, 8'h01, 1'b0, 256, 3'd0, 8'd255, 3'd0, 1'b1, 1'b1};
    tv[3] = '{8'd8,   8'h02, 8'h02, 1'b1, 15,  3'd1, 8'd8,   3'd1, 1'b1, 1'b0};
    tv[4] = '{8'd3,   8'hFF, 8'hFF, 1'b0, 3,   3'd6, 8'd3,   3'd0, 1'b1, 1'b0};
    tv[5] = '{8'd5,   8'h00, 8'h00, 1'b0, 5,   3'd4, 8'd0,   3'd0, 1'b0, 1'b0};
    tv[6] = '{8'd1,   8'h80, 8'h80, 1'b0, 1,   3'd7, 8'd1,   3'd7, 1'b1, 1'b0};
    tv[7] = '{8'd255, 8'hFF, 8'hFF, 1'b0, 255, 3'd2, 8'd255, 3'd0, 1'b1, 1'b0};

    // Reset state
    tick(1'b1, 1'b0, 8'h00, 8'd10, 3'd0);
    chk("rst_fv",   32'(frame_valid),  0);
    chk("rst_win",  32'(winner),       0);
    chk("rst_wv",   32'(winner_valid), 0);
    chk("rst_ov",   32'(overflow),     0);
    chk("rst_rate", 32'(rate_out),     0);

`ifndef SPIKE_DEC_EMA_EN
    for (int v = 0; v < 8; v++) begin
      tick(1'b1, 1'b0, 8'h00, tv[v].wl, tv[v].ch);
      k = 0;
      early = 0;
      for (int c = 0; c < tv[v].cyc; c++) begin
        e  = tv[v].toggle ? (c % 2 == 0) : 1'b1;
        sp = !e ? 8'hFF : ((k % 2 == 0) ? tv[v].sp_even : tv[v].sp_odd);
        if (e) k++;
        tick(1'b0, e, sp, tv[v].wl, tv[v].ch);
        if (c < tv[v].cyc - 1 && frame_valid) early = 1;
      end
      chk($sformatf("tbl%0d_early_fv", v), 32'(early), 0);
      chk($sformatf("tbl%0d_fv", v),   32'(frame_valid),  1);
      chk($sformatf("tbl%0d_rate", v), 32'(rate_out),     32'(tv[v].rate));
      chk($sformatf("tbl%0d_win", v),  32'(winner),       32'(tv[v].win));
      chk($sformatf("tbl%0d_wv", v),   32'(winner_valid), 32'(tv[v].wv));
      chk($sformatf("tbl%0d_ov", v),   32'(overflow),     32'(tv[v].ov));
      tick(1'b0, 1'b0, 8'h00, tv[v].wl, tv[v].ch);
      chk($sformatf("tbl%0d_fv_drop", v), 32'(frame_valid), 0);
      chk($sformatf("tbl%0d_hold", v),    32'(rate_out),    32'(tv[v].rate));
    end
`endif

    // Reset mid-window discards the partial window and clears latched state
    tick(1'b1, 1'b0, 8'h00, 8'd2, 3'd0);
    tick(1'b0, 1'b1, 8'hFF, 8'd2, 3'd0);
    tick(1'b0, 1'b1, 8'hFF, 8'd2, 3'd0);
    check_all("pre_rst");
    for (int c = 0; c < 5; c++) tick(1'b0, 1'b1, 8'h0F, 8'd10, 3'd0);
    tick(1'b1, 1'b1, 8'h0F, 8'd10, 3'd0);
    chk("midrst_fv",   32'(frame_valid),  0);
    chk("midrst_wv",   32'(winner_valid), 0);
    chk("midrst_win",  32'(winner),       0);
    chk("midrst_ov",   32'(overflow),     0);
    chk("midrst_rate", 32'(rate_out),     0);
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, 1'b1, 8'h01, 8'd10, 3'd0);
      check_all("post_rst");
    end
`ifndef SPIKE_DEC_EMA_EN
    chk("post_rst_ch0", 32'(rate_out), 10);
`else
    chk("post_rst_ch0", 32'(rate_out), 5);
`endif

    // win_len change mid-window applies only to the next window
    tick(1'b1, 1'b0, 8'h00, 8'd4, 3'd2);
    tick(1'b0, 1'b1, 8'h04, 8'd4, 3'd2);
    for (int c = 1; c < 12; c++) begin
      tick(1'b0, 1'b1, 8'h04, 8'd6, 3'd2);
      check_all("wl_change");
      if (c == 3 || c == 9) chk("wl_change_edge", 32'(frame_valid), 1);
    end

`ifdef SPIKE_DEC_EMA_EN
    tick(1'b1, 1'b0, 8'h00, 8'd4, 3'd0);
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b1, 8'h01, 8'd4, 3'd0);
    chk("ema_frame1", 32'(rate_out), 2);
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b1, 8'h00, 8'd4, 3'd0);
    chk("ema_frame2", 32'(rate_out), 1);
`endif

    // Randomized traffic against the reference model
    tick(1'b1, 1'b0, 8'h00, 8'd4, 3'd0);
    for (int c = 0; c < 4000; c++) begin
      tick($urandom_range(0, 399) == 0,
           $urandom_range(0, 3) != 0,
           8'($urandom) & 8'($urandom | 32'h0F),
           8'($urandom_range(0, 9)),
           3'($urandom));
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
